// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl
//   Run/step sequencer for the 5-stage pipeline. It takes CLEAR/RUN/STEP/HALT
//   commands from the debug unit and drives the shared pipeline_mode /
//   execute_instruct pair into every pipeline latch (IF_ID .. MEM_WB). It
//   detects program completion from the MEM_WB EOF flag, counts advance cycles
//   and executed steps, and stops a runaway continuous run with a watchdog.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | latches frozen, waiting for RUN or STEP
//   CONT_RUN  | latches advance every cycle (continuous mode)
//   STEP_WAIT | stepwise mode, latches held until the next STEP
//   STEP_EXEC | single advance cycle in stepwise mode (lasts one cycle)
//   DONE      | program finished or watchdog fired; held until CLEAR
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_cmd_valid, i_cmd     command strobe and opcode (00 CLEAR, 01 RUN,
//                          10 STEP, 11 HALT)
//   o_cmd_ready            command is taken when valid & ready
//   i_eof_wb               EOF flag at the MEM_WB latch output
//   o_pipeline_mode        00 frozen, 01 continuous, 11 stepwise
//   o_execute_instruct     one-cycle advance pulse in stepwise mode
//   o_running              high in CONT_RUN or STEP_EXEC
//   o_done                 one-cycle pulse on entry to DONE
//   o_timeout              sticky watchdog flag, cleared by CLEAR in DONE
//   o_cycle_count          latch-advance cycles since last CLEAR
//   o_step_count           STEP_EXEC cycles since last CLEAR
//   o_state                current state for debug readout

module pipeline_run_ctrl #(
    parameter int                  NB_COUNT   = 32,
    parameter logic [NB_COUNT-1:0] MAX_CYCLES = 32'hFFFF_FFFF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_cmd_valid,
    input  logic [1:0]          i_cmd,
    output logic                o_cmd_ready,
    input  logic                i_eof_wb,
    output logic [1:0]          o_pipeline_mode,
    output logic                o_execute_instruct,
    output logic                o_running,
    output logic                o_done,
    output logic                o_timeout,
    output logic [NB_COUNT-1:0] o_cycle_count,
    output logic [NB_COUNT-1:0] o_step_count,
    output logic [2:0]          o_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CONT_RUN  = 3'd1,
        STEP_WAIT = 3'd2,
        STEP_EXEC = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam logic [1:0] CMD_CLEAR = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_HALT  = 2'b11;

    // Last cycle count value before the advance that reaches the limit.
    localparam logic [NB_COUNT-1:0] WD_LAST  = MAX_CYCLES - 1'b1;
    localparam logic [NB_COUNT-1:0] CNT_FULL = '1;

    state_t              state;
    logic [NB_COUNT-1:0] cycle_count;
    logic [NB_COUNT-1:0] step_count;
    logic                done;
    logic                timeout;
    logic                cmd_acc;

    assign o_cmd_ready = (state != STEP_EXEC);
    assign cmd_acc     = i_cmd_valid && o_cmd_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            cycle_count <= '0;
            step_count  <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            done <= 1'b0;

            // Advance-cycle accounting; saturates rather than wrapping.
            if ((state == CONT_RUN || state == STEP_EXEC) && cycle_count != CNT_FULL)
                cycle_count <= cycle_count + 1'b1;
            if (state == STEP_EXEC && step_count != CNT_FULL)
                step_count <= step_count + 1'b1;

            case (state)
                IDLE: begin
                    if (cmd_acc) begin
                        case (i_cmd)
                            CMD_RUN:   state <= CONT_RUN;
                            CMD_STEP:  state <= STEP_EXEC;
                            CMD_CLEAR: begin
                                cycle_count <= '0;
                                step_count  <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                CONT_RUN: begin
                    // EOF wins over the watchdog, both win over commands.
                    if (i_eof_wb) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (cycle_count >= WD_LAST) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else if (cmd_acc) begin
                        case (i_cmd)
                            CMD_HALT: state <= IDLE;
                            CMD_STEP: state <= STEP_WAIT;
                            default: ;
                        endcase
                    end
                end
                STEP_WAIT: begin
                    if (i_eof_wb) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (cmd_acc) begin
                        case (i_cmd)
                            CMD_STEP: state <= STEP_EXEC;
                            CMD_RUN:  state <= CONT_RUN;
                            CMD_HALT: state <= IDLE;
                            default: ;
                        endcase
                    end
                end
                STEP_EXEC: begin
                    if (i_eof_wb) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= STEP_WAIT;
                    end
                end
                DONE: begin
                    if (cmd_acc && i_cmd == CMD_CLEAR) begin
                        state       <= IDLE;
                        cycle_count <= '0;
                        step_count  <= '0;
                        timeout     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_pipeline_mode    = 2'b00;
        o_execute_instruct = 1'b0;
        case (state)
            CONT_RUN:  o_pipeline_mode = 2'b01;
            STEP_WAIT: o_pipeline_mode = 2'b11;
            STEP_EXEC: begin
                o_pipeline_mode    = 2'b11;
                o_execute_instruct = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_running     = (state == CONT_RUN) || (state == STEP_EXEC);
    assign o_done        = done;
    assign o_timeout     = timeout;
    assign o_cycle_count = cycle_count;
    assign o_step_count  = step_count;
    assign o_state       = state;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Testbench for pipeline_run_ctrl: directed scenarios followed by random
// commands and EOF pulses, all checked every cycle against a behavioural model.

module tb_pipeline_run_ctrl;

    localparam int NB   = 32;
    localparam int MAXC = 20;

    localparam logic [1:0] C_CLEAR = 2'b00;
    localparam logic [1:0] C_RUN   = 2'b01;
    localparam logic [1:0] C_STEP  = 2'b10;
    localparam logic [1:0] C_HALT  = 2'b11;

    localparam int S_IDLE = 0, S_RUN = 1, S_WAIT = 2, S_EXEC = 3, S_DONE = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd = 2'b00;
    logic          eof = 1'b0;
    logic          cmd_ready;
    logic [1:0]    mode;
    logic          exec;
    logic          running;
    logic          done;
    logic          timeout;
    logic [NB-1:0] cyc_cnt;
    logic [NB-1:0] stp_cnt;
    logic [2:0]    state;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    // behavioural model
    int      m_state = S_IDLE;
    longint  m_cyc   = 0;
    longint  m_stp   = 0;
    bit      m_to    = 0;
    bit      m_done  = 0;
    localparam longint CNT_MAX = (64'd1 << NB) - 1;

    pipeline_run_ctrl #(.NB_COUNT(NB), .MAX_CYCLES(MAXC)) dut (
        .i_clk             (clk),
        .i_reset           (rst),
        .i_cmd_valid       (cmd_valid),
        .i_cmd             (cmd),
        .o_cmd_ready       (cmd_ready),
        .i_eof_wb          (eof),
        .o_pipeline_mode   (mode),
        .o_execute_instruct(exec),
        .o_running         (running),
        .o_done            (done),
        .o_timeout         (timeout),
        .o_cycle_count     (cyc_cnt),
        .o_step_count      (stp_cnt),
        .o_state           (state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] mode_of(input int s);
        case (s)
            S_RUN:          return 2'b01;
            S_WAIT, S_EXEC: return 2'b11;
            default:        return 2'b00;
        endcase
    endfunction

    function automatic longint sat_inc(input longint v);
        return (v == CNT_MAX) ? v : v + 1;
    endfunction

    // Spec rules applied to one clock edge.
    task automatic model_edge(input bit r, input bit v, input logic [1:0] c, input bit e);
        int  nxt;
        bit  take;
        bit  clr;
        if (r) begin
            m_state = S_IDLE; m_cyc = 0; m_stp = 0; m_to = 0; m_done = 0;
            return;
        end
        take = v && (m_state != S_EXEC);
        clr  = 0;
        nxt  = m_state;
        case (m_state)
            S_IDLE: if (take) begin
                if (c == C_RUN)        nxt = S_RUN;
                else if (c == C_STEP)  nxt = S_EXEC;
                else if (c == C_CLEAR) clr = 1;
            end
            S_RUN: begin
                if (e) nxt = S_DONE;
                else if (m_cyc + 1 >= MAXC) begin nxt = S_DONE; m_to = 1; end
                else if (take && c == C_HALT) nxt = S_IDLE;
                else if (take && c == C_STEP) nxt = S_WAIT;
            end
            S_WAIT: begin
                if (e) nxt = S_DONE;
                else if (take && c == C_STEP) nxt = S_EXEC;
                else if (take && c == C_RUN)  nxt = S_RUN;
                else if (take && c == C_HALT) nxt = S_IDLE;
            end
            S_EXEC: nxt = e ? S_DONE : S_WAIT;
            default: if (take && c == C_CLEAR) begin nxt = S_IDLE; clr = 1; m_to = 0; end
        endcase
        if (m_state == S_RUN || m_state == S_EXEC) m_cyc = sat_inc(m_cyc);
        if (m_state == S_EXEC) m_stp = sat_inc(m_stp);
        if (clr) begin m_cyc = 0; m_stp = 0; end
        m_done  = (nxt == S_DONE) && (m_state != S_DONE);
        m_state = nxt;
    endtask

    task automatic tick(input bit r, input bit v, input logic [1:0] c, input bit e);
        rst = r; cmd_valid = v; cmd = c; eof = e;
        @(posedge clk);
        model_edge(r, v, c, e);
        #1;
        check_val("state",   state,     m_state);
        check_val("mode",    mode,      mode_of(m_state));
        check_val("execute", exec,      m_state == S_EXEC);
        check_val("running", running,   m_state == S_RUN || m_state == S_EXEC);
        check_val("ready",   cmd_ready, m_state != S_EXEC);
        check_val("done",    done,      m_done);
        check_val("timeout", timeout,   m_to);
        check_val("cycles",  cyc_cnt,   m_cyc);
        check_val("steps",   stp_cnt,   m_stp);
        if (exec) pulses++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, C_CLEAR, 0);
    endtask

    task automatic send(input logic [1:0] c);
        tick(0, 1, c, 0);
    endtask

    initial begin
        int budget;
        #2;
        tick(1, 0, C_CLEAR, 0);
        tick(1, 1, C_RUN, 1);
        check_val("rst_state", state, 0);
        check_val("rst_cycles", cyc_cnt, 0);

        // RUN with EOF arriving in the 12th continuous cycle
        send(C_RUN);
        idle(11);
        tick(0, 0, C_CLEAR, 1);
        check_val("t1_cycles", cyc_cnt, 12);
        check_val("t1_steps", stp_cnt, 0);
        check_val("t1_state", state, 4);
        check_val("t1_done", done, 1);
        check_val("t1_timeout", timeout, 0);
        idle(1);
        check_val("t1_done_pulse", done, 0);

        // three single steps
        send(C_CLEAR);
        pulses = 0;
        send(C_STEP);
        idle(1);
        idle(3);
        send(C_STEP);
        idle(1);
        send(C_STEP);
        idle(1);
        check_val("t2_pulses", pulses, 3);
        check_val("t2_steps", stp_cnt, 3);
        check_val("t2_cycles", cyc_cnt, 3);

        // run, halt, resume, then step
        send(C_HALT);
        send(C_CLEAR);
        send(C_RUN);
        idle(4);
        send(C_HALT);
        check_val("t3_mode_halt", mode, 0);
        send(C_RUN);
        idle(3);
        send(C_STEP);
        check_val("t3_cycles", cyc_cnt, 9);
        check_val("t3_state", state, 2);
        idle(2);
        check_val("t3_no_exec", exec, 0);

        // watchdog
        send(C_HALT);
        send(C_CLEAR);
        send(C_RUN);
        budget = 40;
        while (state != 3'd4 && budget > 0) begin idle(1); budget--; end
        check_val("t4_reached_done", state, 4);
        check_val("t4_cycles", cyc_cnt, MAXC);
        check_val("t4_timeout", timeout, 1);
        send(C_CLEAR);
        check_val("t4_clr_timeout", timeout, 0);
        check_val("t4_clr_cycles", cyc_cnt, 0);

        // STEP coinciding with EOF in STEP_WAIT
        pulses = 0;
        send(C_STEP);
        idle(1);
        tick(0, 1, C_STEP, 1);
        check_val("t5_state", state, 4);
        send(C_RUN);
        send(C_STEP);
        check_val("t5_ignored", state, 4);
        check_val("t5_pulses", pulses, 1);

        // reset in the middle of a run
        send(C_CLEAR);
        send(C_RUN);
        idle(3);
        tick(1, 1, C_HALT, 0);
        check_val("t6_state", state, 0);
        check_val("t6_cycles", cyc_cnt, 0);
        check_val("t6_mode", mode, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 199) == 0,
                 $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
